// File: rtl/adlv_res_17.sv
// Resolves a redundant (sum, carry) vector pair into a conventional binary sum,
// CHUNK bits per cycle, with a valid/ready handshake on both sides.
module adlv_res_17 #(
    parameter int BIT   = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [BIT:0]   s_in,
    input  logic [BIT:0]   e_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BIT+1:0] sum_out,
    output logic           busy
);

    localparam int W      = BIT + 1;
    localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
    localparam int LAST_K = NCHUNK - 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic [W-1:0]     s_q, s_d;
    logic [W-1:0]     e_q, e_d;
    logic [W:0]       sum_q, sum_d;
    logic [CHUNK-1:0] s_chunk, e_chunk;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        int base;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        k_d       = k_q;
        c_d       = c_q;
        s_d       = s_q;
        e_d       = e_q;
        sum_d     = sum_q;
        s_chunk   = '0;
        e_chunk   = '0;
        chunk_sum = '0;
        base      = int'(k_q) * CHUNK;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    s_d     = s_in;
                    e_d     = e_in;
                    k_d     = '0;
                    c_d     = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int j = 0; j < CHUNK; j++) begin
                    if (base + j < W) begin
                        s_chunk[j] = s_q[base + j];
                        e_chunk[j] = e_q[base + j];
                    end
                end
                chunk_sum = {1'b0, s_chunk} + {1'b0, e_chunk} + {{CHUNK{1'b0}}, c_q};
                // A short final chunk lands its carry-out directly on the top result bit.
                for (int j = 0; j <= CHUNK; j++) begin
                    if ((j < CHUNK && base + j <= W) || (base + j == W)) begin
                        sum_d[base + j] = chunk_sum[j];
                    end
                end
                c_d = chunk_sum[CHUNK];
                k_d = k_q + 1'b1;
                if (k_q == KW'(LAST_K)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            e_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            s_q     <= s_d;
            e_q     <= e_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_adlv_res_17.sv
// Directed bench for adlv_res_17: table of pairs with hand-computed sums plus
// sequences for backpressure, ignored inputs while busy, and mid-run reset.
module tb_adlv_res_17;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] s_in;
    logic [16:0] e_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] sum_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    adlv_res_17 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s_in     (s_in),
        .e_in     (e_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] s;
        logic [16:0] e;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge with the block idle; waits for the result
    // and expects a 5-edge latency, then one DONE edge with out_ready high.
    task automatic run_pair(input logic [16:0] s, input logic [16:0] e,
                            input logic [17:0] exp, input string name);
        int n;
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        s_in     = s;
        e_in     = e;
        tick();
        in_valid = 1'b0;
        s_in     = '0;
        e_in     = '0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'd5);
        check({name, "_sum"}, 32'(sum_out), 32'(exp));
        out_ready = 1'b1;
        tick();
        check({name, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        logic [17:0] held;
        int n;
        int stray;

        vecs[0] = '{17'h1FFFF, 17'h1FFFF, 18'h3FFFE, "max"};
        vecs[1] = '{17'h00001, 17'h0FFFF, 18'h10000, "ripple"};
        vecs[2] = '{17'h10000, 17'h10000, 18'h20000, "bit16"};
        vecs[3] = '{17'h12345, 17'h0ABCD, 18'h1CF12, "mixed"};
        vecs[4] = '{17'h00000, 17'h00000, 18'h00000, "zero"};
        vecs[5] = '{17'h1FFFF, 17'h00001, 18'h20000, "carry_top"};
        vecs[6] = '{17'h0F0F0, 17'h10F0F, 18'h1FFFF, "alt"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        s_in      = '0;
        e_in      = '0;
        out_ready = 1'b1;

        #2;
        check("reset_outputs", {28'd0, in_ready, out_valid, busy, |sum_out}, 32'b1000);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_pair(vecs[i].s, vecs[i].e, vecs[i].exp, vecs[i].name);
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        s_in      = 17'h01234;
        e_in      = 17'h00F0F;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(n), 32'd5);
        check("bp_sum", 32'(sum_out), 32'h02143);
        held = sum_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {11'd0, out_valid, in_ready, sum_out, 1'b0}, {11'd0, 1'b1, 1'b0, held, 1'b0});
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

        // Inputs presented while busy must be ignored.
        in_valid = 1'b1;
        s_in     = 17'h00003;
        e_in     = 17'h00005;
        tick();
        s_in = 17'h0AAAA;
        e_in = 17'h0AAAA;
        tick();
        check("busy_run", {30'd0, busy, in_ready}, 32'b10);
        tick();
        in_valid = 1'b0;
        n = 2;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("ign_latency", 32'(n), 32'd5);
        check("ign_sum", 32'(sum_out), 32'h00008);
        tick();
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) stray++;
            tick();
        end
        check("ign_no_second", 32'(stray), 32'd0);

        // Asynchronous reset in the middle of RUN.
        in_valid = 1'b1;
        s_in     = 17'h1FFFF;
        e_in     = 17'h1FFFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_run", {28'd0, in_ready, out_valid, busy, |sum_out}, 32'b1000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_pair(17'h00007, 17'h00001, 18'h00008, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
